// File: rtl/mem_io_bus.sv
// -----------------------------------------------------------------------------
// mem_io_bus
// Bus controller between the CPU memory port and a synchronous-read RAM plus
// two memory-mapped I/O registers (LED output, switch input). One request is
// captured in IDLE, decoded, executed, and acknowledged with a single-cycle
// mem_ready pulse. Latency is fixed: 2 cycles for writes, I/O and unmapped
// accesses, 3 cycles for RAM reads (counted from the sampling edge).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_cmd   [1:0]       01 read, 10 write, 00/11 no operation
//   mem_addr  [8:0]       request address
//   cpu_wdata [15:0]      write data
//   cpu_rdata [15:0]      read data, valid while mem_ready=1, held otherwise
//   mem_ready             one-cycle completion pulse
//   ram_addr  [RAM_AW-1:0], ram_wdata [15:0], ram_we   RAM request (EXEC only)
//   ram_rdata [15:0]      RAM read data, one clock after ram_addr
//   sw_in     [7:0]       raw asynchronous switches
//   led_out   [7:0]       LED register
//   bus_err               sticky unmapped-access flag
// -----------------------------------------------------------------------------
module mem_io_bus #(
   parameter int         RAM_AW   = 8,
   parameter logic [8:0] LED_ADDR = 9'h100,
   parameter logic [8:0] SW_ADDR  = 9'h140
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        mem_cmd,
   input  logic [8:0]        mem_addr,
   input  logic [15:0]       cpu_wdata,
   output logic [15:0]       cpu_rdata,
   output logic              mem_ready,
   output logic [RAM_AW-1:0] ram_addr,
   output logic [15:0]       ram_wdata,
   output logic              ram_we,
   input  logic [15:0]       ram_rdata,
   input  logic [7:0]        sw_in,
   output logic [7:0]        led_out,
   output logic              bus_err
);

   localparam logic [1:0] MREAD  = 2'b01;
   localparam logic [1:0] MWRITE = 2'b10;

   typedef enum logic [1:0] {IDLE, EXEC, RWAIT, ACK} state_t;

   state_t      state_q;
   logic        wr_q;
   logic [8:0]  addr_q;
   logic [15:0] data_q;
   logic [15:0] rdata_q;
   logic        ready_q;
   logic [7:0]  led_q;
   logic        err_q;
   logic [7:0]  sw_meta_q;
   logic [7:0]  sw_sync_q;

   logic ram_hit;
   logic led_hit;
   logic sw_hit;
   logic in_exec;

   // Decode always uses the captured address, never the live bus.
   assign ram_hit = ((32'(addr_q) >> RAM_AW) == 32'd0);
   assign led_hit = (addr_q == LED_ADDR);
   assign sw_hit  = (addr_q == SW_ADDR);
   assign in_exec = (state_q == EXEC);

   // RAM strobes come from state and captured request only, so an
   // asynchronous reset during EXEC removes ram_we immediately.
   assign ram_we    = in_exec && wr_q && ram_hit;
   assign ram_addr  = (in_exec && ram_hit) ? addr_q[RAM_AW-1:0] : '0;
   assign ram_wdata = (in_exec && ram_hit && wr_q) ? data_q : '0;

   assign cpu_rdata = rdata_q;
   assign mem_ready = ready_q;
   assign led_out   = led_q;
   assign bus_err   = err_q;

   // Two-flop synchronizer, free-running and independent of the FSM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sw_meta_q <= '0;
         sw_sync_q <= '0;
      end else begin
         sw_meta_q <= sw_in;
         sw_sync_q <= sw_meta_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         rdata_q <= '0;
         ready_q <= 1'b0;
         led_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         ready_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (mem_cmd == MREAD || mem_cmd == MWRITE) begin
                  wr_q    <= (mem_cmd == MWRITE);
                  addr_q  <= mem_addr;
                  data_q  <= cpu_wdata;
                  state_q <= EXEC;
               end
            end
            EXEC: begin
               if (ram_hit) begin
                  if (wr_q) begin
                     state_q <= ACK;
                     ready_q <= 1'b1;
                  end else begin
                     // RAM registers ram_addr at this edge; data arrives in RWAIT.
                     state_q <= RWAIT;
                  end
               end else begin
                  state_q <= ACK;
                  ready_q <= 1'b1;
                  if (led_hit) begin
                     if (wr_q) led_q   <= data_q[7:0];
                     else      rdata_q <= {8'h00, led_q};
                  end else if (sw_hit) begin
                     // Writes to the switch register are silently dropped.
                     if (!wr_q) rdata_q <= {8'h00, sw_sync_q};
                  end else begin
                     err_q <= 1'b1;
                     if (!wr_q) rdata_q <= 16'h0000;
                  end
               end
            end
            RWAIT: begin
               rdata_q <= ram_rdata;
               state_q <= ACK;
               ready_q <= 1'b1;
            end
            ACK: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_io_bus.sv
// -----------------------------------------------------------------------------
// Testbench for mem_io_bus: directed scenarios followed by randomized
// transactions, checked against a transaction-level reference model with a
// behavioural RAM attached to the DUT RAM port.
// -----------------------------------------------------------------------------
module tb_mem_io_bus;

   localparam logic [8:0] LED_A = 9'h100;
   localparam logic [8:0] SW_A  = 9'h140;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  mem_cmd;
   logic [8:0]  mem_addr;
   logic [15:0] cpu_wdata;
   logic [15:0] cpu_rdata;
   logic        mem_ready;
   logic [7:0]  ram_addr;
   logic [15:0] ram_wdata;
   logic        ram_we;
   logic [15:0] ram_rdata;
   logic [7:0]  sw_in;
   logic [7:0]  led_out;
   logic        bus_err;

   always #5 clk = ~clk;

   mem_io_bus #(.RAM_AW(8), .LED_ADDR(LED_A), .SW_ADDR(SW_A)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mem_cmd   (mem_cmd),
      .mem_addr  (mem_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_rdata (cpu_rdata),
      .mem_ready (mem_ready),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_we    (ram_we),
      .ram_rdata (ram_rdata),
      .sw_in     (sw_in),
      .led_out   (led_out),
      .bus_err   (bus_err)
   );

   // Behavioural synchronous-read RAM (read-before-write).
   logic [15:0] ram_arr [256];
   always @(posedge clk) begin
      ram_rdata <= ram_arr[ram_addr];
      if (ram_we) ram_arr[ram_addr] = ram_wdata;
   end

   // Reference state.
   logic [15:0] ref_mem [256];
   logic [7:0]  ref_led;
   logic        ref_err;
   logic [15:0] ref_rd;
   logic [7:0]  ref_sw;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic outs_zero(input string tag);
      chk({tag, "_rdata"}, 32'(cpu_rdata), 32'd0);
      chk({tag, "_ready"}, 32'(mem_ready), 32'd0);
      chk({tag, "_we"},    32'(ram_we),    32'd0);
      chk({tag, "_led"},   32'(led_out),   32'd0);
      chk({tag, "_err"},   32'(bus_err),   32'd0);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         @(negedge clk);
         chk("idle_ready", 32'(mem_ready), 32'd0);
         chk("idle_we",    32'(ram_we),    32'd0);
      end
   endtask

   // Applies one request at a negedge (FSM in IDLE) and returns at a negedge
   // with the FSM back in IDLE.
   task automatic txn(input logic [1:0] cmd, input logic [8:0] a, input logic [15:0] d);
      bit          is_wr, is_ram, is_led, is_sw;
      int          exp_lat, cyc, we_cnt;
      bit          seen;
      logic [15:0] exp_rd;
      is_wr   = (cmd == 2'b10);
      is_ram  = (a < 9'd256);
      is_led  = (a == LED_A);
      is_sw   = (a == SW_A);
      exp_lat = (!is_wr && is_ram) ? 3 : 2;
      if (is_wr)       exp_rd = ref_rd;
      else if (is_ram) exp_rd = ref_mem[a[7:0]];
      else if (is_led) exp_rd = {8'h00, ref_led};
      else if (is_sw)  exp_rd = {8'h00, ref_sw};
      else             exp_rd = 16'h0000;

      mem_cmd   = cmd;
      mem_addr  = a;
      cpu_wdata = d;
      cyc = 0; we_cnt = 0; seen = 0;
      while (!seen && cyc < 10) begin
         @(posedge clk);
         cyc++;
         @(negedge clk);
         if (ram_we) begin
            we_cnt++;
            chk("we_addr",  32'(ram_addr),  32'(a[7:0]));
            chk("we_wdata", 32'(ram_wdata), 32'(d));
         end
         if (mem_ready) seen = 1;
      end
      mem_cmd = 2'b00;
      chk("latency",   32'(cyc),       32'(exp_lat));
      chk("rdata",     32'(cpu_rdata), 32'(exp_rd));
      chk("we_pulses", 32'(we_cnt),    32'((is_wr && is_ram) ? 1 : 0));

      if (is_wr && is_ram) ref_mem[a[7:0]] = d;
      if (is_wr && is_led) ref_led = d[7:0];
      if (!is_ram && !is_led && !is_sw) ref_err = 1'b1;
      ref_rd = exp_rd;
      chk("led", 32'(led_out), 32'(ref_led));
      chk("err", 32'(bus_err), 32'(ref_err));

      @(posedge clk);
      @(negedge clk);
      chk("ready_1cyc", 32'(mem_ready), 32'd0);
      chk("rdata_hold", 32'(cpu_rdata), 32'(exp_rd));
      chk("bus_idle",   {7'd0, ram_we, ram_addr, ram_wdata}, 32'd0);
   endtask

   task automatic model_reset();
      ref_led = 8'h00;
      ref_err = 1'b0;
      ref_rd  = 16'h0000;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit");
      $fatal(1);
   end

   initial begin
      rst_n     = 1'b0;
      mem_cmd   = 2'b00;
      mem_addr  = '0;
      cpu_wdata = '0;
      sw_in     = 8'h00;
      for (int i = 0; i < 256; i++) begin
         ram_arr[i] = 16'($urandom);
         ref_mem[i] = ram_arr[i];
      end
      ram_arr[8'h0F] = 16'h0004;
      ref_mem[8'h0F] = 16'h0004;
      ref_sw = 8'h00;
      model_reset();

      // Reset then idle.
      @(negedge clk);
      @(negedge clk);
      outs_zero("rst0");
      rst_n = 1'b1;
      idle(10);

      // RAM write and read.
      txn(2'b10, 9'h014, 16'd850);
      txn(2'b01, 9'h00F, 16'h0000);
      chk("ram_rd_0F", 32'(cpu_rdata), 32'h0004);

      // I/O registers.
      txn(2'b10, 9'h100, 16'hBEA5);
      chk("led_A5", 32'(led_out), 32'hA5);
      sw_in = 8'h3C;
      ref_sw = 8'h3C;
      idle(3);
      txn(2'b01, 9'h140, 16'h0000);
      chk("sw_rd", 32'(cpu_rdata), 32'h003C);
      txn(2'b01, 9'h100, 16'h0000);
      chk("led_rd", 32'(cpu_rdata), 32'h00A5);
      txn(2'b10, 9'h140, 16'h1234);
      chk("sw_wr_noerr", 32'(bus_err), 32'd0);

      // Unmapped access, then a normal RAM read with sticky error.
      txn(2'b01, 9'h1FF, 16'h0000);
      chk("unmapped_err", 32'(bus_err), 32'd1);
      txn(2'b01, 9'h033, 16'h0000);
      chk("err_sticky", 32'(bus_err), 32'd1);

      // Reset in the middle of a RAM write.
      mem_cmd   = 2'b10;
      mem_addr  = 9'h020;
      cpu_wdata = 16'hDEAD;
      @(posedge clk);
      #2;
      chk("midop_we", 32'(ram_we), 32'd1);
      #1;
      rst_n   = 1'b0;
      mem_cmd = 2'b00;
      #1;
      outs_zero("rst_mid");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(5);
      txn(2'b01, 9'h020, 16'h0000);

      // Randomized traffic.
      for (int i = 0; i < 150; i++) begin
         int          k;
         logic [1:0]  c;
         logic [8:0]  a;
         k = $urandom_range(0, 9);
         if (k == 0) begin
            sw_in  = 8'($urandom);
            ref_sw = sw_in;
            idle(3);
         end else if (k == 1) begin
            mem_cmd  = 2'b11;
            mem_addr = 9'($urandom);
            for (int j = 0; j < 3; j++) begin
               @(posedge clk);
               @(negedge clk);
               chk("cmd11_ready", 32'(mem_ready), 32'd0);
               chk("cmd11_we",    32'(ram_we),    32'd0);
            end
            mem_cmd = 2'b00;
            chk("cmd11_err", 32'(bus_err), 32'(ref_err));
         end else begin
            c = 2'($urandom_range(1, 2));
            case ($urandom_range(0, 3))
               0:       a = {1'b0, 8'($urandom)};
               1:       a = LED_A;
               2:       a = SW_A;
               default: a = {1'b1, 8'($urandom)};
            endcase
            txn(c, a, 16'($urandom));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/mem_io_bus.md
Name: mem_io_bus

Overview:
- Bus controller between the CPU's memory port and the 256x16 read-write memory, plus the memory-mapped LED and switch registers.
- Captures one CPU request (read or write) and decodes its 9-bit address.
- Sequences the synchronous-read RAM or the I/O registers, then returns a one-cycle mem_ready pulse with read data.
- Gives the CPU a fixed, deterministic-latency load/store handshake.

Parameters:
- RAM_AW, 8, RAM address width; RAM window is 0x000 to 2^RAM_AW-1.
- LED_ADDR, 9'h100, address of the LED output register.
- SW_ADDR, 9'h140, address of the switch input register.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_cmd  in  2  2'b00 MNONE, 2'b01 MREAD, 2'b10 MWRITE; 2'b11 is treated as MNONE.
- mem_addr  in  9  request address.
- cpu_wdata  in  16  write data.
- cpu_rdata  out  16  read data; valid while mem_ready=1.
- mem_ready  out  1  one-cycle completion pulse.
- ram_addr  out  RAM_AW  RAM address.
- ram_wdata  out  16  RAM write data.
- ram_we  out  1  RAM write enable.
- ram_rdata  in  16  RAM read data, registered by the RAM one clock after ram_addr.
- sw_in  in  8  raw asynchronous switches.
- led_out  out  8  LED register.
- bus_err  out  1  sticky flag: an unmapped address was accessed.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - State goes to IDLE.
  - cpu_rdata=0, mem_ready=0, ram_we=0, led_out=0, bus_err=0.
  - Request capture registers and switch synchronizer clear to 0.
- States: IDLE, EXEC, RWAIT, ACK.
- IDLE:
  - If mem_cmd is MREAD or MWRITE at the edge, capture cmd, mem_addr and cpu_wdata, then go to EXEC.
  - Otherwise stay in IDLE.
  - Inputs are ignored in every other state.
- Address decode uses the captured address:
  - RAM hit: addr[8]=0.
  - LED hit: addr==LED_ADDR.
  - SW hit: addr==SW_ADDR.
  - Anything else is unmapped.
- EXEC, RAM write:
  - ram_we=1 for exactly this cycle.
  - ram_addr=addr[7:0], ram_wdata=captured data.
  - Next state ACK.
- EXEC, RAM read: drive ram_addr, ram_we=0, next state RWAIT.
- RWAIT: latch ram_rdata into cpu_rdata, next state ACK.
- EXEC, LED:
  - Write loads led_out with data[7:0]; the LED updates at the EXEC->ACK edge.
  - Read loads cpu_rdata={8'h00,led_out}.
  - Next state ACK.
- EXEC, SW:
  - Read loads cpu_rdata={8'h00,sw_sync}.
  - Write is ignored, with no error.
  - Next state ACK.
- EXEC, unmapped:
  - bus_err set to 1 and held until reset.
  - Read loads cpu_rdata=16'h0000.
  - Write has no effect.
  - Next state ACK.
- ACK: mem_ready=1 for this cycle only, cpu_rdata stable; next state IDLE.
- cpu_rdata holds its last value outside ACK and changes only on reads.
- Latency, counted from the sampling edge:
  - mem_ready is high in the 2nd cycle after sampling for writes, I/O reads and unmapped accesses.
  - mem_ready is high in the 3rd cycle after sampling for RAM reads.
- CPU contract:
  - Hold mem_cmd, mem_addr and cpu_wdata until mem_ready is seen.
  - In the cycle after mem_ready, drive MNONE or a new request.
  - A command still present when the FSM returns to IDLE is a new access; a write is re-executed.
- ram_we is decoded from state and captured address only, never from live inputs. Reset mid-EXEC therefore drops ram_we immediately, and no partial write occurs after reset.
- Switch synchronizer:
  - Two-flop: sw_sync is sw_in delayed by 2 edges.
  - Sampled continuously, independent of the FSM.
  - An SW read returns the synchronized value as of the EXEC cycle.
- When not in EXEC, ram_addr, ram_wdata and ram_we are all 0.
- mem_cmd=2'b11 is never captured and does not set bus_err.

Test Plan:
- Reset then idle: assert rst_n=0 mid-cycle -> all outputs 0 immediately; with mem_cmd=MNONE for 10 cycles -> mem_ready never high, ram_we never high.
- RAM write: MWRITE addr=0x014, data=16'd850 -> ram_we=1 for exactly one cycle with ram_addr=0x14, ram_wdata=850; mem_ready pulses 2 cycles after the sampling edge.
- RAM read: model RAM holding mem[0x0F]=16'h0004; MREAD 0x00F -> mem_ready in the 3rd cycle; cpu_rdata=16'h0004, still held after the pulse.
- I/O: MWRITE 0x100 data=16'hBEA5 -> led_out=8'hA5. sw_in=8'h3C for 3 cycles, then MREAD 0x140 -> cpu_rdata=16'h003C. MREAD 0x100 -> 16'h00A5. MWRITE 0x140 -> bus_err stays 0.
- Unmapped access: MREAD 0x1FF -> cpu_rdata=0 and bus_err=1. A following valid RAM read completes normally while bus_err stays 1 until rst_n=0.
- Reset mid-operation: MWRITE 0x020, assert rst_n low during EXEC -> ram_we falls at once and no mem_ready follows. After release with MNONE the FSM stays in IDLE; the next MREAD completes with RAM-read latency.
